spll_bit_slicer: RTL and testbench
==================================

Name: spll_bit_slicer

Overview:
Downstream consumer of the software PLL's phase/error outputs. Detects the recovered-clock rising edge from the phase accumulator MSB and samples the serial data line on that edge. Qualifies lock from the PLL error stream and deserializes sampled bits into words. Presents each word on a valid/ready interface to the framing logic.

Parameters:
PHASE_BITS, 32, width of the incoming phase word (matches the PLL).
WORD_BITS, 8, bits per output word (2..32).
LOCK_COUNT, 64, consecutive error-free CE cycles needed to declare lock (>=2).
UNLOCK_ERRS, 16, leaky error count that drops lock (>=2).

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous active-high reset
i_ce  in  1  sample enable, same strobe that drives the PLL
i_phase  in  PHASE_BITS  PLL phase accumulator (o_phase)
i_err  in  2  PLL error code: 00 none, 01 lag, 11 lead
i_data  in  1  synchronized serial data line
o_locked  out  1  lock qualified
o_word  out  WORD_BITS  deserialized word, MSB = first bit received
o_valid  out  1  o_word holds an unconsumed word
i_ready  in  1  consumer accepts o_word when o_valid && i_ready
o_overrun  out  1  one-cycle pulse: completed word dropped

Behaviour:
- Reset (async, immediate): all state and outputs cleared: o_locked=0, o_word=0, o_valid=0, o_overrun=0, prev_msb=0, all counters 0, FSM=UNLOCKED.
- Edge detect: prev_msb <= i_phase[PHASE_BITS-1] on every i_ce cycle. strobe = i_ce && !prev_msb && i_phase[PHASE_BITS-1]. Non-CE cycles hold all state.
- Lock FSM, states UNLOCKED, ACQUIRE, LOCKED, evaluated only on i_ce:
  - UNLOCKED: i_err==00 -> ACQUIRE with good_cnt=1; otherwise stay.
  - ACQUIRE: i_err==00 -> good_cnt+1; reaching LOCK_COUNT -> LOCKED, bad_cnt=0. Any i_err!=00 -> UNLOCKED, good_cnt=0.
  - LOCKED: i_err!=00 -> bad_cnt+1, saturating. Error-free strobe cycle -> bad_cnt-1, floor 0. If both would apply, the increment wins. bad_cnt reaching UNLOCK_ERRS -> UNLOCKED, good_cnt=0.
  - i_err==10 is treated as an error.
- o_locked registered: =1 exactly while FSM==LOCKED. It asserts on the cycle after the LOCK_COUNT-th good CE sample.
- Deserializer:
  - Active only while FSM==LOCKED at the strobe cycle.
  - On strobe: shift <= {shift, bit}; bit_cnt+1.
  - When bit_cnt reaches WORD_BITS: bit_cnt=0 and the completed word is offered to the output register.
- Output register:
  - Offered word is loaded when !o_valid, or when o_valid && i_ready in the same cycle. In the latter case o_valid stays 1 and the old word counts as consumed.
  - Otherwise the new word is discarded, o_valid and o_word are unchanged, and o_overrun pulses 1 for one cycle.
  - o_valid && i_ready with no offer -> o_valid=0; o_word holds its value.
- Leaving LOCKED for any reason clears shift and bit_cnt, so the partial word is lost. A pending o_valid word is kept until consumed.
- Latency: the strobe that samples the last bit is followed by o_valid=1 on the next clock edge.
- i_ready is ignored while o_valid=0. o_word is stable while o_valid && !i_ready.

Optional Feature:
SPLL_SLICER_MAJORITY_EN
- Defined: keeps a 2-deep history of i_data captured on the previous two i_ce cycles. The sampled bit is the majority of {hist1, hist0, i_data} at the strobe. History updates on every i_ce, locked or not.
- Undefined: sampled bit = i_data at the strobe cycle; no history registers.

Test Plan:
- Reset mid-word: lock, shift 5 bits, assert i_reset asynchronously between clock edges -> all outputs 0 immediately; after release the next word needs 8 fresh bits.
- Lock acquire (LOCK_COUNT=64): 63 error-free CE cycles then err=01 -> o_locked stays 0. Then 64 clean cycles -> o_locked=1 the cycle after the 64th.
- Unlock (UNLOCK_ERRS=16): while locked, inject 16 err=11 CE cycles with no clean strobes -> o_locked=0. The partially shifted word is discarded and a pending o_valid word is retained.
- Word capture (WORD_BITS=8, i_ready=1): send bits 1,0,1,0,0,1,0,1 on 8 strobes -> o_word=8'hA5, o_valid=1 for one cycle.
- Backpressure: i_ready=0, send 8'h3C then 8'hF0 -> o_word stays 8'h3C, o_overrun pulses once when the second word completes. Raising i_ready then drops o_valid.
- Majority (macro defined): i_data glitches 0 for one CE cycle at the strobe inside a run of 1s -> sampled bit 1. With the macro undefined the same stimulus gives 0.

Source files
------------

// File: rtl/spll_bit_slicer.sv
// spll_bit_slicer: recovered-clock edge detect, lock qualification and word deserializer for the software PLL.
// Define SPLL_SLICER_MAJORITY_EN to sample the majority of the last three CE data values.
module spll_bit_slicer #(
    parameter int PHASE_BITS  = 32,
    parameter int WORD_BITS   = 8,
    parameter int LOCK_COUNT  = 64,
    parameter int UNLOCK_ERRS = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ce,
    input  logic [PHASE_BITS-1:0] i_phase,
    input  logic [1:0]            i_err,
    input  logic                  i_data,
    output logic                  o_locked,
    output logic [WORD_BITS-1:0]  o_word,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_overrun
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_ERRS + 1);
    localparam int CW = $clog2(WORD_BITS + 1);
    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
    state_t state_q, state_d;
    logic prev_msb_q, prev_msb_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic [BW-1:0] bad_cnt_q, bad_cnt_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] shift_q, shift_d, word_q, word_d, shifted;
    logic locked_q, locked_d, valid_q, valid_d, overrun_q, overrun_d;
    logic msb, strobe, clean, bit_in, offer, unused_phase;

    assign msb = i_phase[PHASE_BITS-1];
    assign unused_phase = ^i_phase[PHASE_BITS-2:0];
    assign strobe = i_ce && !prev_msb_q && msb;
    assign clean = (i_err == 2'b00);
    assign shifted = {shift_q[WORD_BITS-2:0], bit_in};

`ifdef SPLL_SLICER_MAJORITY_EN
    logic hist0_q, hist0_d, hist1_q, hist1_d;
    always_comb begin
        hist0_d = i_ce ? i_data : hist0_q;
        hist1_d = i_ce ? hist0_q : hist1_q;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hist0_q <= 1'b0;
            hist1_q <= 1'b0;
        end else begin
            hist0_q <= hist0_d;
            hist1_q <= hist1_d;
        end
    end
    assign bit_in = (hist1_q & hist0_q) | (hist1_q & i_data) | (hist0_q & i_data);
`else
    assign bit_in = i_data;
`endif

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        prev_msb_d = i_ce ? msb : prev_msb_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        offer      = 1'b0;
        if (i_ce) begin
            case (state_q)
                UNLOCKED: if (clean) begin
                    state_d    = ACQUIRE;
                    good_cnt_d = GW'(1);
                end
                ACQUIRE: if (!clean) begin
                    state_d    = UNLOCKED;
                    good_cnt_d = '0;
                end else if (good_cnt_q == GW'(LOCK_COUNT - 1)) begin
                    state_d    = LOCKED;
                    good_cnt_d = GW'(LOCK_COUNT);
                    bad_cnt_d  = '0;
                end else begin
                    good_cnt_d = good_cnt_q + GW'(1);
                end
                LOCKED: begin
                    // an error outranks a clean strobe in the same cycle
                    if (!clean)
                        bad_cnt_d = (bad_cnt_q == BW'(UNLOCK_ERRS)) ? bad_cnt_q : bad_cnt_q + BW'(1);
                    else if (strobe && bad_cnt_q != '0)
                        bad_cnt_d = bad_cnt_q - BW'(1);
                    if (bad_cnt_d == BW'(UNLOCK_ERRS)) begin
                        state_d    = UNLOCKED;
                        good_cnt_d = '0;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
        if (state_q == LOCKED && strobe) begin
            shift_d   = shifted;
            offer     = (bit_cnt_q == CW'(WORD_BITS - 1));
            bit_cnt_d = offer ? '0 : bit_cnt_q + CW'(1);
        end
        if (state_q == LOCKED && state_d != LOCKED) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end
        valid_d   = valid_q;
        word_d    = word_q;
        overrun_d = 1'b0;
        if (offer) begin
            if (!valid_q || i_ready) begin
                word_d  = shifted;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= UNLOCKED;
            prev_msb_q <= 1'b0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            word_q     <= '0;
            locked_q   <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_msb_q <= prev_msb_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            locked_q   <= locked_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_locked  = locked_q;
    assign o_word    = word_q;
    assign o_valid   = valid_q;
    assign o_overrun = overrun_q;
endmodule

// File: tb/tb_spll_bit_slicer.sv
// tb_spll_bit_slicer: directed and random stimulus against a queue-based reference model with a decoupled monitor.
module tb_spll_bit_slicer;
    localparam int PB = 32;
    localparam int W  = 8;
    localparam int LC = 64;
    localparam int UE = 16;

    logic i_clk, i_reset, i_ce, i_data, i_ready;
    logic [PB-1:0] i_phase;
    logic [1:0] i_err;
    logic o_locked, o_valid, o_overrun;
    logic [W-1:0] o_word;

    int n_checks = 0;
    int n_fail = 0;

    spll_bit_slicer #(.PHASE_BITS(PB), .WORD_BITS(W), .LOCK_COUNT(LC), .UNLOCK_ERRS(UE)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_phase(i_phase), .i_err(i_err),
        .i_data(i_data), .o_locked(o_locked), .o_word(o_word), .o_valid(o_valid),
        .i_ready(i_ready), .o_overrun(o_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: lock = run of clean CE samples, unlock = leaky error count
    logic m_prev, m_h0, m_h1, m_locked, m_valid, m_over, mo, mb, mst;
    logic [W-1:0] m_word, mw, mon_w;
    int m_run, m_leak;
    logic bits[$];
    logic [W-1:0] exp_q[$];

    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_prev = 0; m_h0 = 0; m_h1 = 0; m_locked = 0; m_valid = 0; m_over = 0;
            m_word = '0; m_run = 0; m_leak = 0;
            bits.delete();
            exp_q.delete();
        end else begin
            mo = 0;
            if (i_ce) begin
                mst = !m_prev && i_phase[PB-1];
                m_prev = i_phase[PB-1];
`ifdef SPLL_SLICER_MAJORITY_EN
                mb = (int'(m_h1) + int'(m_h0) + int'(i_data)) >= 2;
`else
                mb = i_data;
`endif
                m_h1 = m_h0;
                m_h0 = i_data;
                if (m_locked && mst) begin
                    bits.push_back(mb);
                    if (bits.size() == W) begin
                        mw = '0;
                        foreach (bits[k]) mw = {mw[W-2:0], bits[k]};
                        mo = 1;
                        bits.delete();
                    end
                end
                if (!m_locked) begin
                    m_run = (i_err == 2'b00) ? m_run + 1 : 0;
                    if (m_run >= LC) begin m_locked = 1; m_leak = 0; end
                end else begin
                    if (i_err != 2'b00) m_leak++;
                    else if (mst && m_leak > 0) m_leak--;
                    if (m_leak >= UE) begin m_locked = 0; m_run = 0; bits.delete(); end
                end
            end
            m_over = mo && m_valid && !i_ready;
            if (mo && !m_over) begin
                m_word = mw;
                m_valid = 1;
                exp_q.push_back(mw);
            end else if (!mo && m_valid && i_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge i_clk) begin
        check("mon_locked", 32'(o_locked), 32'(m_locked));
        check("mon_valid", 32'(o_valid), 32'(m_valid));
        check("mon_overrun", 32'(o_overrun), 32'(m_over));
        if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_word: got %0h with no word expected", o_word);
            end else begin
                mon_w = exp_q.pop_front();
                check("mon_word", 32'(o_word), 32'(mon_w));
            end
        end
    end

    task automatic drive(input logic ce, input logic msb, input logic [1:0] err, input logic d, input logic rdy);
        i_ce = ce;
        i_phase = {msb, 31'($urandom)};
        i_err = err;
        i_data = d;
        i_ready = rdy;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic rdy);
        drive(1'b1, 1'b0, 2'b00, b, rdy);
        drive(1'b1, 1'b1, 2'b00, b, rdy);
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic rdy);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i], rdy);
    endtask

    task automatic clean_cycles(input int n, input logic rdy);
        repeat (n) drive(1'b1, 1'b0, 2'b00, 1'b0, rdy);
    endtask

    task automatic check_outputs(input string nm, input logic lk, input logic v, input logic [W-1:0] w, input logic ov);
        check({nm, "_locked"}, 32'(o_locked), 32'(lk));
        check({nm, "_valid"}, 32'(o_valid), 32'(v));
        check({nm, "_word"}, 32'(o_word), 32'(w));
        check({nm, "_overrun"}, 32'(o_overrun), 32'(ov));
    endtask

    initial begin
        i_reset = 1; i_ce = 0; i_phase = '0; i_err = 0; i_data = 0; i_ready = 0;
        repeat (2) @(posedge i_clk);
        #1;
        check_outputs("reset", 0, 0, 8'h00, 0);
        i_reset = 0;

        clean_cycles(LC - 1, 1);
        drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
        check("lock_63_then_err", 32'(o_locked), 0);
        clean_cycles(LC - 1, 1);
        check("lock_63", 32'(o_locked), 0);
        clean_cycles(1, 1);
        check("lock_64", 32'(o_locked), 1);

        send_word(8'hA5, 1);
        check_outputs("word_a5", 1, 1, 8'hA5, 0);
        clean_cycles(1, 1);
        check("word_a5_consumed", 32'(o_valid), 0);

        send_word(8'h3C, 0);
        check_outputs("bp_first", 1, 1, 8'h3C, 0);
        send_word(8'hF0, 0);
        check_outputs("bp_overrun", 1, 1, 8'h3C, 1);
        clean_cycles(1, 0);
        check_outputs("bp_hold", 1, 1, 8'h3C, 0);
        clean_cycles(1, 1);
        check("bp_drain", 32'(o_valid), 0);

        for (int i = 0; i < 3; i++) send_bit(1'b1, 1);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
`ifdef SPLL_SLICER_MAJORITY_EN
        check("glitch_word", 32'(o_word), 32'h0000_00FF);
`else
        check("glitch_word", 32'(o_word), 32'h0000_00EF);
`endif
        clean_cycles(1, 1);

        send_word(8'h5A, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        repeat (UE - 1) drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
        check("unlock_15", 32'(o_locked), 1);
        drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
        check_outputs("unlock_16", 0, 1, 8'h5A, 0);
        clean_cycles(1, 1);
        check("unlock_consumed", 32'(o_valid), 0);
        clean_cycles(LC - 1, 1);
        check("relock", 32'(o_locked), 1);
        send_word(8'h99, 1);
        check_outputs("after_unlock", 1, 1, 8'h99, 0);

        send_word(8'hC3, 0);
        for (int i = 0; i < 5; i++) send_bit(i[0], 0);
        #2;
        i_reset = 1;
        #1;
        check_outputs("async_reset", 0, 0, 8'h00, 0);
        i_ce = 0;
        @(posedge i_clk);
        #3;
        i_reset = 0;
        @(posedge i_clk);
        #1;
        clean_cycles(LC, 1);
        check("reset_relock", 32'(o_locked), 1);
        send_word(8'h81, 1);
        check_outputs("reset_fresh_word", 1, 1, 8'h81, 0);

        repeat (4000)
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 49) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
        repeat (4) drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        check("drain_queue", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
